// File: rtl/debug_ocimem_sequencer.sv
// debug_ocimem_sequencer: turns debug-slave OCI memory strobes into debug memory bus transactions
module debug_ocimem_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, mon_q, mon_d;
  logic rd_q, rd_d, wr_q, wr_d, ready_q, ready_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ld, rd_cmd, wr_cmd, busy, accept, done, tmo;
  assign ld     = take_action_ocimem_a;
  assign rd_cmd = ld ? jdo[35] : (!take_action_ocimem_b && take_no_action_ocimem_a);
  assign wr_cmd = !ld && take_action_ocimem_b;
  assign busy   = state_q != IDLE;
  assign accept = (state_q == RD_REQ || state_q == WR_REQ) && !mem_waitrequest;
  assign done   = (state_q == WR_REQ && !mem_waitrequest) ||
                  (((state_q == RD_REQ && !mem_waitrequest) || state_q == RD_WAIT) && mem_readdatavalid);
  // completion in the final allowed cycle beats the timeout
  assign tmo    = busy && !done && cnt_q >= CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ready_d = ready_q;
    err_d   = ld ? 1'b0 : err_q;
    cnt_d   = busy ? cnt_q + 1'b1 : cnt_q;
    if (!busy) begin
      if (rd_cmd) begin
        state_d = RD_REQ;
        rd_d    = 1'b1;
        ready_d = 1'b0;
        cnt_d   = '0;
      end else if (wr_cmd) begin
        state_d = WR_REQ;
        wr_d    = 1'b1;
        wdata_d = jdo[34:3];
        ready_d = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      if (rd_cmd || wr_cmd) err_d = 1'b1;
      if (accept) begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
      if (done) begin
        state_d = IDLE;
        ready_d = 1'b1;
        addr_d  = addr_q + 1'b1;
        mon_d   = state_q == WR_REQ ? mon_q : mem_readdata;
      end else if (tmo) begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ready_d = 1'b1;
        err_d   = 1'b1;
      end else if (accept) begin
        state_d = RD_WAIT;
      end
    end
    if (ld) addr_d = jdo[17 +: ADDR_W];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
endmodule

// File: tb/tb_debug_ocimem_sequencer.sv
// tb_debug_ocimem_sequencer: directed checks of the OCI memory sequencer with a hand-driven memory
module tb_debug_ocimem_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic a = 1'b0, n = 1'b0, b = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata, mem_readdata = '0, MonDReg;
  logic mem_read, mem_write, mem_waitrequest = 1'b0, mem_readdatavalid = 1'b0;
  logic monitor_ready, monitor_error;
  int checks = 0, fails = 0;
  debug_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(a), .take_no_action_ocimem_a(n), .take_action_ocimem_b(b),
    .jdo(jdo), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [37:0] ja(input logic rd, input logic [7:0] ad);
    return (38'(rd) << 35) | (38'(ad) << 17);
  endfunction
  function automatic logic [37:0] jb(input logic [31:0] d);
    return 38'(d) << 3;
  endfunction
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(monitor_ready), 1);
    chk("rst_error", 32'(monitor_error), 0);
    chk("rst_read", 32'(mem_read), 0);
    chk("rst_write", 32'(mem_write), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_mon", MonDReg, 0);
    // load address 0x10 and read it
    a = 1'b1; jdo = ja(1'b1, 8'h10);
    tick();
    a = 1'b0;
    chk("t1_read", 32'(mem_read), 1);
    chk("t1_addr", 32'(mem_addr), 32'h10);
    chk("t1_busy", 32'(monitor_ready), 0);
    tick();
    chk("t1_read_acc", 32'(mem_read), 0);
    chk("t1_wait_busy", 32'(monitor_ready), 0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'hA5A5_0001;
    tick();
    mem_readdatavalid = 1'b0;
    chk("t1_mon", MonDReg, 32'hA5A5_0001);
    chk("t1_addr_inc", 32'(mem_addr), 32'h11);
    chk("t1_ready", 32'(monitor_ready), 1);
    // three writes wrapping through 0xFF
    a = 1'b1; jdo = ja(1'b0, 8'hFE);
    tick();
    a = 1'b0;
    chk("t2_load", 32'(mem_addr), 32'hFE);
    chk("t2_noread", 32'(mem_read), 0);
    for (int i = 1; i <= 3; i++) begin
      logic [7:0] ea;
      ea = 8'hFE + 8'(i - 1);
      b = 1'b1; jdo = jb(32'(i));
      tick();
      b = 1'b0;
      chk("t2_write", 32'(mem_write), 1);
      chk("t2_wdata", mem_wdata, 32'(i));
      chk("t2_waddr", 32'(mem_addr), 32'(ea));
      tick();
      chk("t2_done", 32'(mem_write), 0);
      chk("t2_ready", 32'(monitor_ready), 1);
    end
    chk("t2_final_addr", 32'(mem_addr), 32'h01);
    chk("t2_error", 32'(monitor_error), 0);
    // write stalled 5 cycles, accepted on the 6th
    b = 1'b1; jdo = jb(32'hDEAD_BEEF); mem_waitrequest = 1'b1;
    tick();
    b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("t3_hold_write", 32'(mem_write), 1);
      chk("t3_hold_data", mem_wdata, 32'hDEAD_BEEF);
      chk("t3_hold_busy", 32'(monitor_ready), 0);
      tick();
    end
    mem_waitrequest = 1'b0;
    chk("t3_6th_write", 32'(mem_write), 1);
    chk("t3_6th_addr", 32'(mem_addr), 32'h01);
    tick();
    chk("t3_done", 32'(mem_write), 0);
    chk("t3_ready", 32'(monitor_ready), 1);
    chk("t3_error", 32'(monitor_error), 0);
    chk("t3_addr", 32'(mem_addr), 32'h02);
    // read with no readdatavalid: abort after 8 busy cycles
    n = 1'b1;
    tick();
    n = 1'b0;
    chk("t4_read", 32'(mem_read), 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t4_busy", 32'(monitor_ready), 0);
      chk("t4_noerr", 32'(monitor_error), 0);
    end
    tick();
    chk("t4_ready", 32'(monitor_ready), 1);
    chk("t4_error", 32'(monitor_error), 1);
    chk("t4_mon", MonDReg, 32'hA5A5_0001);
    chk("t4_addr", 32'(mem_addr), 32'h02);
    chk("t4_read_off", 32'(mem_read), 0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'hFFFF_FFFF;
    tick();
    mem_readdatavalid = 1'b0;
    chk("t4_stray", MonDReg, 32'hA5A5_0001);
    chk("t4_stray_addr", 32'(mem_addr), 32'h02);
    a = 1'b1; jdo = ja(1'b0, 8'h30);
    tick();
    a = 1'b0;
    chk("t4_clear", 32'(monitor_error), 0);
    chk("t4_load", 32'(mem_addr), 32'h30);
    // write strobe during RD_WAIT is an overrun
    n = 1'b1;
    tick();
    n = 1'b0;
    chk("t5_read", 32'(mem_read), 1);
    tick();
    b = 1'b1; jdo = jb(32'h0000_1234);
    tick();
    b = 1'b0;
    chk("t5_overrun", 32'(monitor_error), 1);
    chk("t5_nowrite", 32'(mem_write), 0);
    chk("t5_busy", 32'(monitor_ready), 0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'hCAFE_F00D;
    tick();
    mem_readdatavalid = 1'b0;
    chk("t5_mon", MonDReg, 32'hCAFE_F00D);
    chk("t5_addr", 32'(mem_addr), 32'h31);
    chk("t5_ready", 32'(monitor_ready), 1);
    chk("t5_sticky", 32'(monitor_error), 1);
    chk("t5_wdata", mem_wdata, 32'hDEAD_BEEF);
    // reset while a write is stalled
    b = 1'b1; jdo = jb(32'h0000_0055); mem_waitrequest = 1'b1;
    tick();
    b = 1'b0;
    chk("t6_write", 32'(mem_write), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_waitrequest = 1'b0;
    chk("t6_write_off", 32'(mem_write), 0);
    chk("t6_addr", 32'(mem_addr), 0);
    chk("t6_ready", 32'(monitor_ready), 1);
    chk("t6_error", 32'(monitor_error), 0);
    chk("t6_mon", MonDReg, 0);
    chk("t6_wdata", mem_wdata, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
